// File: rtl/riscmakers_icache_tag_array.sv
// riscmakers_icache_tag_array: N-way I-cache tag/valid store, 1-cycle lookup, sweep clear.
// Optional per-way even parity over {valid,tag}: define RISCMAKERS_ICACHE_TAG_PARITY_EN.
module riscmakers_icache_tag_array #(
   parameter int TAG_WIDTH = 20,
   parameter int NUM_SETS  = 256,
   parameter int NUM_WAYS  = 4,
   localparam int SET_W = $clog2(NUM_SETS),
   localparam int WAY_W = $clog2(NUM_WAYS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   output logic                 req_gnt_o,
   input  logic [SET_W-1:0]     req_set_i,
   input  logic [TAG_WIDTH-1:0] req_tag_i,
   output logic                 rsp_valid_o,
   output logic                 rsp_hit_o,
   output logic [WAY_W-1:0]     rsp_way_o,
   output logic [NUM_WAYS-1:0]  rsp_vld_ways_o,
   output logic                 rsp_par_err_o,
   input  logic                 wr_i,
   input  logic [SET_W-1:0]     wr_set_i,
   input  logic [WAY_W-1:0]     wr_way_i,
   input  logic [TAG_WIDTH-1:0] wr_tag_i,
   input  logic                 inv_i,
   input  logic [SET_W-1:0]     inv_set_i,
   input  logic                 flush_i,
   output logic                 busy_o
);
`ifdef RISCMAKERS_ICACHE_TAG_PARITY_EN
   localparam int WORD_W = TAG_WIDTH + 2;
`else
   localparam int WORD_W = TAG_WIDTH + 1;
`endif

   typedef enum logic {SWEEP, IDLE} state_t;

   state_t               r_state, w_state_nxt;
   logic [SET_W-1:0]     r_cnt, w_cnt_nxt;
   logic [WORD_W-1:0]    r_mem [NUM_WAYS][NUM_SETS];
   logic [WORD_W-1:0]    r_rd [NUM_WAYS];
   logic [TAG_WIDTH-1:0] r_tag;
   logic                 r_rsp_vld, r_seen;
   logic                 w_idle, w_gnt, w_wr_act, w_inv_act;
   logic [NUM_WAYS-1:0]  w_we, w_vld, w_hitv, w_perr;
   logic [SET_W-1:0]     w_wset;
   logic [WORD_W-1:0]    w_wdata;
   logic [WAY_W-1:0]     w_way;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= SWEEP;
         r_cnt     <= '0;
         r_rsp_vld <= 1'b0;
         r_seen    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rsp_vld <= w_gnt;
         if (w_gnt) r_seen <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      if (r_state == SWEEP) begin
         w_cnt_nxt = r_cnt + 1'b1;
         if (r_cnt == SET_W'(NUM_SETS - 1)) w_state_nxt = IDLE;
      end
      if (flush_i) begin
         w_state_nxt = SWEEP;
         w_cnt_nxt   = '0;
      end
   end

   // sweep owns the write port; in IDLE flush > wr > inv > req
   always_comb begin
      w_idle    = (r_state == IDLE);
      w_wr_act  = w_idle & ~flush_i & wr_i;
      w_inv_act = w_idle & ~flush_i & ~wr_i & inv_i;
      w_gnt     = w_idle & ~flush_i & ~wr_i & ~inv_i & req_i;
      w_we      = '0;
      w_wset    = r_cnt;
      w_wdata   = '0;
      if (!w_idle) begin
         w_we = '1;
      end else if (w_wr_act) begin
         w_we[wr_way_i] = 1'b1;
         w_wset         = wr_set_i;
`ifdef RISCMAKERS_ICACHE_TAG_PARITY_EN
         w_wdata = {^{1'b1, wr_tag_i}, 1'b1, wr_tag_i};
`else
         w_wdata = {1'b1, wr_tag_i};
`endif
      end else if (w_inv_act) begin
         w_we   = '1;
         w_wset = inv_set_i;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (w_we[w]) r_mem[w][w_wset] <= w_wdata;
         if (w_gnt) r_rd[w] <= r_mem[w][req_set_i];
      end
      if (w_gnt) r_tag <= req_tag_i;
   end

   always_comb begin
      w_perr = '0;
      w_vld  = '0;
      w_hitv = '0;
      w_way  = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
`ifdef RISCMAKERS_ICACHE_TAG_PARITY_EN
         w_perr[w] = ^r_rd[w];
`endif
         w_vld[w]  = r_rd[w][TAG_WIDTH] & ~w_perr[w];
         w_hitv[w] = w_vld[w] & (r_rd[w][TAG_WIDTH-1:0] == r_tag);
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (w_hitv[w]) w_way = WAY_W'(w);
      end
   end

   // r_seen masks the unreset read registers until the first lookup
   assign req_gnt_o      = w_gnt;
   assign busy_o         = ~w_idle;
   assign rsp_valid_o    = r_rsp_vld;
   assign rsp_hit_o      = r_seen & (|w_hitv);
   assign rsp_way_o      = r_seen ? w_way : '0;
   assign rsp_vld_ways_o = r_seen ? w_vld : '0;
`ifdef RISCMAKERS_ICACHE_TAG_PARITY_EN
   assign rsp_par_err_o  = r_seen & (|w_perr);
`else
   assign rsp_par_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_riscmakers_icache_tag_array.sv
// tb_riscmakers_icache_tag_array: directed bench for the I-cache tag array.
// Parity scenario is exercised when RISCMAKERS_ICACHE_TAG_PARITY_EN is defined.
module tb_riscmakers_icache_tag_array;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        req_gnt_o;
   logic [7:0]  req_set_i = '0;
   logic [19:0] req_tag_i = '0;
   logic        rsp_valid_o, rsp_hit_o, rsp_par_err_o, busy_o;
   logic [1:0]  rsp_way_o;
   logic [3:0]  rsp_vld_ways_o;
   logic        wr_i = 1'b0;
   logic [7:0]  wr_set_i = '0;
   logic [1:0]  wr_way_i = '0;
   logic [19:0] wr_tag_i = '0;
   logic        inv_i = 1'b0;
   logic [7:0]  inv_set_i = '0;
   logic        flush_i = 1'b0;

   int n_pass = 0;
   int n_tot  = 0;

   logic       g, v, h, v2, h2, pe;
   logic [1:0] wy;
   logic [3:0] vw;
   int         nb;

   always #5 clk_i = ~clk_i;

   riscmakers_icache_tag_array dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_i(req_i), .req_gnt_o(req_gnt_o),
      .req_set_i(req_set_i), .req_tag_i(req_tag_i),
      .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o),
      .rsp_way_o(rsp_way_o), .rsp_vld_ways_o(rsp_vld_ways_o),
      .rsp_par_err_o(rsp_par_err_o),
      .wr_i(wr_i), .wr_set_i(wr_set_i), .wr_way_i(wr_way_i),
      .wr_tag_i(wr_tag_i), .inv_i(inv_i), .inv_set_i(inv_set_i),
      .flush_i(flush_i), .busy_o(busy_o)
   );

   // all helpers start and end on a falling edge
   task automatic do_lookup(input logic [7:0] s, input logic [19:0] t);
      req_i = 1'b1; req_set_i = s; req_tag_i = t;
      #1 g = req_gnt_o;
      @(negedge clk_i);
      req_i = 1'b0;
      v = rsp_valid_o; h = rsp_hit_o; wy = rsp_way_o;
      vw = rsp_vld_ways_o; pe = rsp_par_err_o;
      @(negedge clk_i);
      v2 = rsp_valid_o; h2 = rsp_hit_o;
   endtask

   task automatic do_write(input logic [7:0] s, input logic [1:0] w, input logic [19:0] t);
      wr_i = 1'b1; wr_set_i = s; wr_way_i = w; wr_tag_i = t;
      @(negedge clk_i);
      wr_i = 1'b0;
   endtask

   task automatic do_inv(input logic [7:0] s);
      inv_i = 1'b1; inv_set_i = s;
      @(negedge clk_i);
      inv_i = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy_o === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk_i);
      end
   endtask

   task automatic test_reset;
      @(negedge clk_i);
      @(negedge clk_i);
      n_tot++; if (req_gnt_o !== 1'b0) $display("FAIL rst_gnt got=%b exp=0", req_gnt_o); else n_pass++;
      n_tot++; if (rsp_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", rsp_valid_o); else n_pass++;
      n_tot++; if (rsp_hit_o !== 1'b0) $display("FAIL rst_hit got=%b exp=0", rsp_hit_o); else n_pass++;
      n_tot++; if (rsp_way_o !== 2'd0) $display("FAIL rst_way got=%0d exp=0", rsp_way_o); else n_pass++;
      n_tot++; if (rsp_vld_ways_o !== 4'b0) $display("FAIL rst_vld got=%b exp=0000", rsp_vld_ways_o); else n_pass++;
      n_tot++; if (rsp_par_err_o !== 1'b0) $display("FAIL rst_perr got=%b exp=0", rsp_par_err_o); else n_pass++;
      n_tot++; if (busy_o !== 1'b1) $display("FAIL rst_busy got=%b exp=1", busy_o); else n_pass++;
      rst_ni = 1'b1;
      count_busy(nb);
      n_tot++; if (nb != 256) $display("FAIL rst_sweep_len got=%0d exp=256", nb); else n_pass++;
   endtask

   task automatic test_empty_lookup;
      do_lookup(8'd9, 20'h00000);
      n_tot++; if (g !== 1'b1) $display("FAIL empty_gnt got=%b exp=1", g); else n_pass++;
      n_tot++; if (v !== 1'b1) $display("FAIL empty_valid got=%b exp=1", v); else n_pass++;
      n_tot++; if (h !== 1'b0) $display("FAIL empty_hit got=%b exp=0", h); else n_pass++;
      n_tot++; if (vw !== 4'b0000) $display("FAIL empty_vld got=%b exp=0000", vw); else n_pass++;
      n_tot++; if (pe !== 1'b0) $display("FAIL empty_perr got=%b exp=0", pe); else n_pass++;
   endtask

   task automatic test_write_hit;
      do_write(8'd5, 2'd2, 20'hABCDE);
      do_lookup(8'd5, 20'hABCDE);
      n_tot++; if (g !== 1'b1) $display("FAIL wrhit_gnt got=%b exp=1", g); else n_pass++;
      n_tot++; if (v !== 1'b1) $display("FAIL wrhit_valid got=%b exp=1", v); else n_pass++;
      n_tot++; if (h !== 1'b1) $display("FAIL wrhit_hit got=%b exp=1", h); else n_pass++;
      n_tot++; if (wy !== 2'd2) $display("FAIL wrhit_way got=%0d exp=2", wy); else n_pass++;
      n_tot++; if (vw !== 4'b0100) $display("FAIL wrhit_vld got=%b exp=0100", vw); else n_pass++;
      n_tot++; if (v2 !== 1'b0) $display("FAIL wrhit_pulse got=%b exp=0", v2); else n_pass++;
      n_tot++; if (h2 !== 1'b1) $display("FAIL wrhit_hold got=%b exp=1", h2); else n_pass++;
      do_lookup(8'd5, 20'hABCDF);
      n_tot++; if (h !== 1'b0) $display("FAIL tagmiss_hit got=%b exp=0", h); else n_pass++;
      n_tot++; if (vw !== 4'b0100) $display("FAIL tagmiss_vld got=%b exp=0100", vw); else n_pass++;
   endtask

   task automatic test_multi_way;
      do_write(8'd7, 2'd3, 20'h12345);
      do_write(8'd7, 2'd1, 20'h12345);
      do_lookup(8'd7, 20'h12345);
      n_tot++; if (h !== 1'b1) $display("FAIL multi_hit got=%b exp=1", h); else n_pass++;
      n_tot++; if (wy !== 2'd1) $display("FAIL multi_way got=%0d exp=1", wy); else n_pass++;
      n_tot++; if (vw !== 4'b1010) $display("FAIL multi_vld got=%b exp=1010", vw); else n_pass++;
      do_inv(8'd7);
      do_lookup(8'd7, 20'h12345);
      n_tot++; if (h !== 1'b0) $display("FAIL inv_hit got=%b exp=0", h); else n_pass++;
      n_tot++; if (vw !== 4'b0000) $display("FAIL inv_vld got=%b exp=0000", vw); else n_pass++;
      do_lookup(8'd5, 20'hABCDE);
      n_tot++; if (h !== 1'b1) $display("FAIL inv_other_hit got=%b exp=1", h); else n_pass++;
   endtask

   task automatic test_back_to_back;
      req_i = 1'b1; req_set_i = 8'd10; req_tag_i = 20'h11111;
      wr_i = 1'b1; wr_set_i = 8'd10; wr_way_i = 2'd0; wr_tag_i = 20'h11111;
      #1;
      n_tot++; if (req_gnt_o !== 1'b0) $display("FAIL b2b_blocked got=%b exp=0", req_gnt_o); else n_pass++;
      @(negedge clk_i);
      wr_i = 1'b0;
      do_lookup(8'd10, 20'h11111);
      n_tot++; if (g !== 1'b1) $display("FAIL b2b_gnt got=%b exp=1", g); else n_pass++;
      n_tot++; if (h !== 1'b1 || wy !== 2'd0) $display("FAIL b2b_hit got=%b/%0d exp=1/0", h, wy); else n_pass++;
      req_i = 1'b1; req_set_i = 8'd5; req_tag_i = 20'hABCDE;
      @(negedge clk_i);
      req_i = 1'b0; flush_i = 1'b1;
      n_tot++; if (rsp_valid_o !== 1'b1 || rsp_hit_o !== 1'b1) $display("FAIL flushrsp got=%b/%b exp=1/1", rsp_valid_o, rsp_hit_o); else n_pass++;
      n_tot++; if (rsp_way_o !== 2'd2) $display("FAIL flushrsp_way got=%0d exp=2", rsp_way_o); else n_pass++;
      @(negedge clk_i);
      flush_i = 1'b0;
      n_tot++; if (busy_o !== 1'b1) $display("FAIL flush_busy got=%b exp=1", busy_o); else n_pass++;
      count_busy(nb);
      n_tot++; if (nb != 256) $display("FAIL flush_len got=%0d exp=256", nb); else n_pass++;
      do_lookup(8'd5, 20'hABCDE);
      n_tot++; if (h !== 1'b0 || vw !== 4'b0000) $display("FAIL flush_clr got=%b/%b exp=0/0000", h, vw); else n_pass++;
   endtask

   task automatic test_flush_mid;
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      repeat (100) @(negedge clk_i);
      n_tot++; if (busy_o !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy_o); else n_pass++;
      req_i = 1'b1; #1;
      n_tot++; if (req_gnt_o !== 1'b0) $display("FAIL busy_gnt got=%b exp=0", req_gnt_o); else n_pass++;
      req_i = 1'b0; flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      count_busy(nb);
      n_tot++; if (nb != 256) $display("FAIL restart_len got=%0d exp=256", nb); else n_pass++;
   endtask

   task automatic test_reset_mid;
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      repeat (50) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      n_tot++; if (busy_o !== 1'b1 || rsp_hit_o !== 1'b0) $display("FAIL midrst got=%b/%b exp=1/0", busy_o, rsp_hit_o); else n_pass++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      count_busy(nb);
      n_tot++; if (nb != 256) $display("FAIL midrst_len got=%0d exp=256", nb); else n_pass++;
   endtask

   task automatic test_parity;
`ifdef RISCMAKERS_ICACHE_TAG_PARITY_EN
      logic [21:0] bad;
      bad = {^{1'b1, 20'h00333}, 1'b1, 20'h00332};
      do_write(8'd3, 2'd1, 20'h00332);
      wr_i = 1'b1; wr_set_i = 8'd3; wr_way_i = 2'd0; wr_tag_i = 20'h00333;
      force dut.w_wdata = bad;
      @(negedge clk_i);
      release dut.w_wdata;
      wr_i = 1'b0;
      do_lookup(8'd3, 20'h00332);
      n_tot++; if (pe !== 1'b1) $display("FAIL par_err got=%b exp=1", pe); else n_pass++;
      n_tot++; if (h !== 1'b1 || wy !== 2'd1) $display("FAIL par_hit got=%b/%0d exp=1/1", h, wy); else n_pass++;
      n_tot++; if (vw !== 4'b0010) $display("FAIL par_vld got=%b exp=0010", vw); else n_pass++;
`else
      do_write(8'd3, 2'd0, 20'h00333);
      do_lookup(8'd3, 20'h00333);
      n_tot++; if (pe !== 1'b0) $display("FAIL nopar_err got=%b exp=0", pe); else n_pass++;
      n_tot++; if (h !== 1'b1 || wy !== 2'd0) $display("FAIL nopar_hit got=%b/%0d exp=1/0", h, wy); else n_pass++;
      n_tot++; if (vw !== 4'b0001) $display("FAIL nopar_vld got=%b exp=0001", vw); else n_pass++;
`endif
   endtask

   initial begin
      test_reset;
      test_empty_lookup;
      test_write_hit;
      test_multi_way;
      test_back_to_back;
      test_flush_mid;
      test_reset_mid;
      test_parity;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
